// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Fixed-priority DM/IF winner selection with a starvation guard for IF.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   grant_take,
    output logic   grant_valid,
    output owner_e grant_owner
);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    starved;

    // DM wins ties unless IF has been passed over STARVE_LIMIT times in a row
    always_comb begin
        starved     = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));
        grant_valid = if_req | dm_req;
        grant_owner = (dm_req && !(if_req && starved)) ? OWNER_DM : OWNER_IF;
    end

    // Count DM grants made while IF waits; any idle IF cycle or IF grant resets it
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req) begin
            starve_cnt_d = '0;
        end else if (grant_take) begin
            if (grant_owner == OWNER_IF) begin
                starve_cnt_d = '0;
            end else if (!starved) begin
                starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the IF and DM ports, one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  pipe_stall
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e          state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                if_valid_q,  if_valid_d;
    logic                dm_valid_q,  dm_valid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;

    logic                grant_take;
    logic                grant_valid;
    owner_e              grant_owner;
    logic                resp_capture;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .dm_req      (dm_req),
        .grant_take  (grant_take),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Next state, command latch in IDLE and response routing to the owner
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        grant_take   = 1'b0;
        resp_capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    owner_d    = grant_owner;
                    mem_req_d  = 1'b1;
                    state_d    = ISSUE;
                    if (grant_owner == OWNER_DM) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_wstrb_d = dm_we ? dm_wstrb : '0;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_rvalid) begin
                        resp_capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp_capture = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_capture) begin
            state_d = RESP;
            if (owner_q == OWNER_DM) begin
                dm_valid_d = 1'b1;
                dm_rdata_d = mem_rdata;
            end else begin
                if_valid_d = 1'b1;
                if_rdata_d = mem_rdata;
            end
        end
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign if_valid   = if_valid_q;
    assign dm_valid   = dm_valid_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;

    // Either port is waiting on its response
    assign pipe_stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule
